// File: rtl/gravity_job_scheduler.sv
// gravity_job_scheduler: round-robin arbiter sharing one gravity engine with a watchdog on each job
module gravity_job_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W = $clog2(NUM_REQ),
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               eng_start,
  input  logic               eng_done,
  input  logic               eng_in_orbit,
  output logic [NUM_REQ-1:0] resp_valid,
  output logic               resp_in_orbit,
  output logic               timeout_err,
  output logic               busy,
  output logic [15:0]        served_cnt
);
  localparam int KW = SEL_W + 1;
  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;
  state_t state, nxt;
  logic [SEL_W-1:0] ptr, ptr_d, win, sel_d;
  logic [KW-1:0] k;
  logic [7:0] wcnt, wcnt_d;
  logic [NUM_REQ-1:0] grant_d, resp_valid_d;
  logic [15:0] served_d;
  logic start_d, orbit_d, tmo_d, busy_d, last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      wcnt <= '0;
      grant <= '0;
      sel <= '0;
      eng_start <= 1'b0;
      resp_valid <= '0;
      resp_in_orbit <= 1'b0;
      timeout_err <= 1'b0;
      busy <= 1'b0;
      served_cnt <= '0;
    end else begin
      state <= nxt;
      ptr <= ptr_d;
      wcnt <= wcnt_d;
      grant <= grant_d;
      sel <= sel_d;
      eng_start <= start_d;
      resp_valid <= resp_valid_d;
      resp_in_orbit <= orbit_d;
      timeout_err <= tmo_d;
      busy <= busy_d;
      served_cnt <= served_d;
    end
  end
  always_comb begin
    last = wcnt == 8'(TIMEOUT - 1);
    nxt = state == IDLE ? (|req ? START : IDLE) :
          state == START ? WAIT :
          state == WAIT ? ((eng_done || last) ? RESP : WAIT) : IDLE;
  end
  always_comb begin
    win = '0;
    k = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = {1'b0, ptr} + KW'(i);
      k = k >= KW'(NUM_REQ) ? k - KW'(NUM_REQ) : k;
      win = req[k[SEL_W-1:0]] ? k[SEL_W-1:0] : win;
    end
    grant_d = nxt == IDLE ? '0 : state == IDLE ? NUM_REQ'(1) << win : grant;
    sel_d = nxt == IDLE ? '0 : state == IDLE ? win : sel;
    start_d = nxt == START;
    wcnt_d = state == WAIT ? wcnt + 8'd1 : '0;
    resp_valid_d = (state == WAIT && nxt == RESP) ? grant : '0;
    orbit_d = state == WAIT && eng_done && eng_in_orbit;
    tmo_d = state == WAIT && !eng_done && last;
    busy_d = nxt != IDLE;
    served_d = served_cnt + 16'(state == WAIT && eng_done);
    ptr_d = state == RESP ? (sel == SEL_W'(NUM_REQ - 1) ? '0 : sel + 1'b1) : ptr;
  end
endmodule
